// File: rtl/gte_mac_accum_pkg.sv
// Shared GTE definitions: MAC stage states,
// accumulator geometry and IR saturation bounds.
package gte_mac_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FINAL = 2'd2
  } EMACST;

  localparam int GTE_ACC_W = 44;
  localparam int GTE_FRAC  = 12;

  localparam logic signed [31:0] GTE_IR_HI = 32'sd32767;
  localparam logic signed [31:0] GTE_IR_LO = -32'sd32768;

endpackage

// File: rtl/gte_ir_saturate.sv
// Clamp a signed 32-bit MAC value into the 16-bit IR range,
// lower bound 0 when lm is set.
module gte_ir_saturate
  import gte_mac_accum_pkg::*;
(
  input  logic [31:0] mac,
  input  logic        lm,
  output logic [15:0] ir,
  output logic        sat
);

  logic signed [31:0] val;
  logic signed [31:0] lo;

  always_comb begin
    val = mac;
    lo  = lm ? 32'sd0 : GTE_IR_LO;
    ir  = val[15:0];
    sat = 1'b0;
    if (val > GTE_IR_HI) begin
      ir  = GTE_IR_HI[15:0];
      sat = 1'b1;
    end else if (val < lo) begin
      ir  = lo[15:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/gte_mac_accum.sv
// Per-lane GTE MAC accumulator: sums signed products into a
// 44-bit accumulator and produces MACn, IRn and overflow flags.
module gte_mac_accum
  import gte_mac_accum_pkg::*;
#(
  parameter int PROD_W = 35,
  parameter int ACC_W  = GTE_ACC_W,
  parameter int OUT_W  = 32,
  parameter int FRAC   = GTE_FRAC
) (
  input  logic              i_clk,
  input  logic              i_nRst,
  input  logic              i_start,
  input  logic [ACC_W-1:0]  i_preload,
  input  logic              i_prodValid,
  input  logic [PROD_W-1:0] i_product,
  input  logic              i_last,
  input  logic              i_sf,
  input  logic              i_lm,
  output logic              o_busy,
  output logic              o_valid,
  output logic [OUT_W-1:0]  o_mac,
  output logic [15:0]       o_ir,
  output logic              o_flagMacPos,
  output logic              o_flagMacNeg,
  output logic              o_flagIrSat
);

  EMACST            state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, base;
  logic [ACC_W:0]   sum;
  logic             pos_q, pos_d;
  logic             neg_q, neg_d;
  logic             ovf_pos, ovf_neg;
  logic             do_add;
  logic [OUT_W-1:0] mac_d;
  logic [15:0]      ir_d;
  logic             sat_d;

  // A start replaces the accumulator, so the add uses the preload.
  always_comb begin
    base = i_start ? i_preload : acc_q;
    sum = {base[ACC_W-1], base}
        + {{(ACC_W+1-PROD_W){i_product[PROD_W-1]}}, i_product};
    ovf_pos = ~sum[ACC_W] & sum[ACC_W-1];
    ovf_neg = sum[ACC_W] & ~sum[ACC_W-1];
    do_add = i_prodValid & (i_start | (state_q == ACCUM));
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    pos_d   = pos_q;
    neg_d   = neg_q;
    if (i_start) begin
      state_d = ACCUM;
      acc_d   = i_preload;
      pos_d   = 1'b0;
      neg_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE:    state_d = IDLE;
        ACCUM:   state_d = ACCUM;
        FINAL:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    if (do_add) begin
      acc_d = sum[ACC_W-1:0];
      pos_d = pos_d | ovf_pos;
      neg_d = neg_d | ovf_neg;
      if (i_last) state_d = FINAL;
    end
  end

  // Results are formed on the edge into FINAL so o_valid lands
  // in the cycle right after the last beat.
  always_comb begin
    mac_d = i_sf ? acc_d[FRAC+OUT_W-1:FRAC] : acc_d[OUT_W-1:0];
  end

  gte_ir_saturate u_sat (
    .mac (mac_d),
    .lm  (i_lm),
    .ir  (ir_d),
    .sat (sat_d)
  );

  always_ff @(posedge i_clk) begin
    if (!i_nRst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      pos_q        <= 1'b0;
      neg_q        <= 1'b0;
      o_valid      <= 1'b0;
      o_mac        <= '0;
      o_ir         <= '0;
      o_flagMacPos <= 1'b0;
      o_flagMacNeg <= 1'b0;
      o_flagIrSat  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
      o_valid <= (state_d == FINAL);
      if (state_d == FINAL) begin
        o_mac        <= mac_d;
        o_ir         <= ir_d;
        o_flagMacPos <= pos_d;
        o_flagMacNeg <= neg_d;
        o_flagIrSat  <= sat_d;
      end
    end
  end

  assign o_busy = (state_q != IDLE);

endmodule
